// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner keep ownership for up to MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_chk
        $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    logic [IW-1:0] rr_q, rr_d, start, idx, pick, win;
    logic          pick_ok, found, xfer;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Scanning downward lets the candidate closest to start overwrite the others.
    always_comb begin
        idx     = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(start) + k) % NUM_REQ);
            if (req[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign xfer      = found && !full && !reset;
    assign wr        = xfer;
    assign ack       = xfer ? NUM_REQ'(1) << win : '0;
    assign w_data    = xfer ? req_data[win*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_idx = xfer ? win : '0;

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold;

    assign hold  = state_q == BURST && req[owner_q];
    assign start = state_q == BURST ? inc(owner_q) : rr_q;
    assign win   = hold ? owner_q : pick;
    assign found = hold || pick_ok;

    // A withdrawn owner releases and the rotation restarts behind it in the same cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        if (!full) begin
            if (hold) begin
                cnt_d = cnt_q + 1'b1;
                if (int'(cnt_d) == MAX_BURST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rr_d    = inc(owner_q);
                end
            end else begin
                if (state_q == BURST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rr_d    = inc(owner_q);
                end
                if (pick_ok) begin
                    owner_d = pick;
                    state_d = MAX_BURST == 1 ? IDLE : BURST;
                    cnt_d   = MAX_BURST == 1 ? '0 : CW'(1);
                    rr_d    = MAX_BURST == 1 ? inc(pick) : rr_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end
`else
    assign start = rr_q;
    assign win   = pick;
    assign found = pick_ok;
    assign rr_d  = xfer ? inc(win) : rr_q;

    always_ff @(posedge clk) begin
        if (reset) rr_q <= '0;
        else rr_q <= rr_d;
    end
`endif
endmodule
